temp_monitor: RTL and testbench

Parametrised temperature post-processor between the I2C temperature controller (or the test switches) and the display formatter. It accepts two's-complement fixed-point samples through a valid/ready handshake. For each sample it maintains a sliding-window average, running min/max and an over-temperature alarm with hysteresis. It publishes one mode-selected value per sample to the display path, and that value can be frozen with a hold input.

---
 rtl/temp_monitor_pkg.sv | 22 ++
 rtl/temp_avg_window.sv | 57 +++++
 rtl/temp_monitor.sv | 124 ++++++++++++
 tb/tb_temp_monitor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_monitor_pkg.sv
// Shared types and width helpers for the temperature post-processor.
package temp_monitor_pkg;

  typedef enum logic [1:0] {
    MODE_CUR = 2'd0,
    MODE_AVG = 2'd1,
    MODE_MIN = 2'd2,
    MODE_MAX = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_PUBLISH = 2'd2
  } state_e;

  // Accumulator must hold N full-scale samples without overflow.
  function automatic int acc_width(input int tw, input int avg_log2);
    return tw + avg_log2;
  endfunction

endpackage

// File: rtl/temp_avg_window.sv
// Sliding-window average over the last 2^AVG_LOG2 samples; empty slots read as zero.
module temp_avg_window
  import temp_monitor_pkg::*;
#(
  parameter int TW       = 13,
  parameter int AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          upd_i,
  input  logic [TW-1:0] sample_i,
  output logic [TW-1:0] avg_o,
  output logic          full_o
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int AW = acc_width(TW, AVG_LOG2);
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CW = AVG_LOG2 + 1;

  logic signed [AW-1:0] acc_q;
  logic [PW-1:0]        ptr_q;
  logic [CW-1:0]        cnt_q;
  logic [TW-1:0]        buf_q [N];

  logic signed [AW-1:0] s_ext, old_ext, acc_shr;

  assign full_o  = (cnt_q == CW'(N));
  assign s_ext   = AW'($signed(sample_i));
  assign old_ext = full_o ? AW'($signed(buf_q[ptr_q])) : '0;
  assign acc_shr = acc_q >>> AVG_LOG2;
  assign avg_o   = acc_shr[TW-1:0];

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (upd_i) begin
      acc_q <= acc_q + s_ext - old_ext;
      ptr_q <= (ptr_q == PW'(N - 1)) ? '0 : ptr_q + 1'b1;
      if (!full_o) cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: the sample buffer has no reset; a slot is only read once the fill count proves it was written.
  always_ff @(posedge clk) begin
    if (upd_i && !clr_i) buf_q[ptr_q] <= sample_i;
  end

endmodule

// File: rtl/temp_monitor.sv
// Temperature post-processor: accept, accumulate statistics and alarm, publish one mode-selected value.
module temp_monitor
  import temp_monitor_pkg::*;
#(
  parameter int TW       = 13,
  parameter int FRAC     = 4,
  parameter int AVG_LOG2 = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] sample_i,
  input  logic          sample_valid_i,
  output logic          sample_ready_o,
  input  logic [1:0]    mode_i,
  input  logic          hold_i,
  input  logic          clr_i,
  input  logic [TW-1:0] thr_hi_i,
  input  logic [TW-1:0] thr_lo_i,
  output logic [TW-1:0] temp_o,
  output logic          temp_valid_o,
  output logic [TW-1:0] min_o,
  output logic [TW-1:0] max_o,
  output logic          mm_valid_o,
  output logic          window_full_o,
  output logic          alarm_o
);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 5 || FRAC < 0 || FRAC >= TW) begin : g_param_check
    $error("temp_monitor: illegal AVG_LOG2/FRAC for TW");
  end

  state_e        state_q;
  logic [TW-1:0] sample_q, temp_q, min_q, max_q;
  logic          temp_valid_q, mm_valid_q, alarm_q, clr_pend_q;
  logic [TW-1:0] avg, pub_val;
  logic          clr_now, win_upd;

  // A clear requested while busy waits for S_IDLE so the window never changes mid-sample.
  assign clr_now = (state_q == S_IDLE) && (clr_i || clr_pend_q);
  assign win_upd = (state_q == S_ACCUM);

  temp_avg_window #(
    .TW       (TW),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr_now),
    .upd_i    (win_upd),
    .sample_i (sample_q),
    .avg_o    (avg),
    .full_o   (window_full_o)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pub_val = sample_q;
    case (mode_e'(mode_i))
      MODE_AVG: pub_val = avg;
      MODE_MIN: if (mm_valid_q) pub_val = min_q;
      MODE_MAX: if (mm_valid_q) pub_val = max_q;
      default:  pub_val = sample_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sample_q     <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      min_q        <= '0;
      max_q        <= '0;
      mm_valid_q   <= 1'b0;
      alarm_q      <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      temp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          clr_pend_q <= 1'b0;
          if (clr_now) mm_valid_q <= 1'b0;
          if (sample_valid_i) begin
            sample_q <= sample_i;
            state_q  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (clr_i) clr_pend_q <= 1'b1;
          if (!mm_valid_q) begin
            min_q      <= sample_q;
            max_q      <= sample_q;
            mm_valid_q <= 1'b1;
          end else begin
            if ($signed(sample_q) < $signed(min_q)) min_q <= sample_q;
            if ($signed(sample_q) > $signed(max_q)) max_q <= sample_q;
          end
          // Set is tested first so misordered thresholds resolve to an active alarm.
          if ($signed(sample_q) > $signed(thr_hi_i))      alarm_q <= 1'b1;
          else if ($signed(sample_q) < $signed(thr_lo_i)) alarm_q <= 1'b0;
          state_q <= S_PUBLISH;
        end
        S_PUBLISH: begin
          if (clr_i) clr_pend_q <= 1'b1;
          if (!hold_i) begin
            temp_q       <= pub_val;
            temp_valid_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sample_ready_o = (state_q == S_IDLE) && !rst;
  assign temp_o         = temp_q;
  assign temp_valid_o   = temp_valid_q;
  assign min_o          = min_q;
  assign max_o          = max_q;
  assign mm_valid_o     = mm_valid_q;
  assign alarm_o        = alarm_q;

endmodule

// File: tb/tb_temp_monitor.sv
// Directed plus random bench for temp_monitor with window depths 8 and 2 against a sample-history model.
module tb_temp_monitor;

  localparam int TW = 13;
  localparam int NW [2] = '{8, 2};

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] sample_i;
  logic          sample_valid_i;
  logic [1:0]    mode_i;
  logic          hold_i, clr_i;
  logic [TW-1:0] thr_hi_i, thr_lo_i;

  logic          rdy   [2];
  logic [TW-1:0] tmp   [2];
  logic          tv    [2];
  logic [TW-1:0] mn    [2];
  logic [TW-1:0] mx    [2];
  logic          mmv   [2];
  logic          wf    [2];
  logic          al    [2];

  int thr_hi = 4095, thr_lo = -4096;
  assign thr_hi_i = thr_hi[TW-1:0];
  assign thr_lo_i = thr_lo[TW-1:0];

  always #5 clk = ~clk;

  temp_monitor #(.TW(TW), .FRAC(4), .AVG_LOG2(3)) u_dut8 (
    .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(rdy[0]), .mode_i(mode_i), .hold_i(hold_i), .clr_i(clr_i),
    .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i), .temp_o(tmp[0]), .temp_valid_o(tv[0]),
    .min_o(mn[0]), .max_o(mx[0]), .mm_valid_o(mmv[0]), .window_full_o(wf[0]), .alarm_o(al[0])
  );

  temp_monitor #(.TW(TW), .FRAC(4), .AVG_LOG2(1)) u_dut2 (
    .clk(clk), .rst(rst), .sample_i(sample_i), .sample_valid_i(sample_valid_i),
    .sample_ready_o(rdy[1]), .mode_i(mode_i), .hold_i(hold_i), .clr_i(clr_i),
    .thr_hi_i(thr_hi_i), .thr_lo_i(thr_lo_i), .temp_o(tmp[1]), .temp_valid_o(tv[1]),
    .min_o(mn[1]), .max_o(mx[1]), .mm_valid_o(mmv[1]), .window_full_o(wf[1]), .alarm_o(al[1])
  );

  int compared = 0;
  int mismatched = 0;

  // Reference state: every sample since the last clear, plus the published value per DUT.
  int hist [$];
  int m_temp [2];
  bit m_alarm;
  bit m_clr_pend;

  function automatic logic [TW-1:0] tw(input int x);
    return x[TW-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int floor_div(input int num, input int den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic int model_avg(input int n);
    int sum = 0;
    for (int i = 0; i < n && i < hist.size(); i++) sum += hist[hist.size() - 1 - i];
    return floor_div(sum, n);
  endfunction

  function automatic int model_min();
    int r = hist[0];
    foreach (hist[i]) if (hist[i] < r) r = hist[i];
    return r;
  endfunction

  function automatic int model_max();
    int r = hist[0];
    foreach (hist[i]) if (hist[i] > r) r = hist[i];
    return r;
  endfunction

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, "_temp"}, 32'(tmp[k]), 32'd0);
      check({tag, "_tv"},   32'(tv[k]),  32'd0);
      check({tag, "_min"},  32'(mn[k]),  32'd0);
      check({tag, "_max"},  32'(mx[k]),  32'd0);
      check({tag, "_mmv"},  32'(mmv[k]), 32'd0);
      check({tag, "_full"}, 32'(wf[k]),  32'd0);
      check({tag, "_alarm"},32'(al[k]),  32'd0);
      check({tag, "_rdy"},  32'(rdy[k]), 32'd0);
    end
  endtask

  // Called in the low phase of clk; returns on the falling edge after the publish edge.
  task automatic send(input int v, input int m, input bit hold, input bit clr_mid, input bit keep_valid);
    int pub;
    for (int k = 0; k < 2; k++) check("ready_idle", 32'(rdy[k]), 32'd1);
    sample_i = tw(v);
    sample_valid_i = 1'b1;
    mode_i = m[1:0];
    hold_i = hold;
    @(posedge clk);
    if (m_clr_pend) begin
      hist.delete();
      m_clr_pend = 1'b0;
    end
    hist.push_back(v);
    if (v > thr_hi) m_alarm = 1'b1;
    else if (v < thr_lo) m_alarm = 1'b0;
    #1;
    sample_valid_i = keep_valid;
    if (clr_mid) clr_i = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("ready_accum", 32'(rdy[k]), 32'd0);
      check("tv_accum", 32'(tv[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    sample_valid_i = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("ready_publish", 32'(rdy[k]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      case (m)
        1:       pub = model_avg(NW[k]);
        2:       pub = model_min();
        3:       pub = model_max();
        default: pub = v;
      endcase
      if (!hold) m_temp[k] = pub;
      check("temp_valid", 32'(tv[k]), 32'(!hold));
      check("temp", 32'(tmp[k]), 32'(tw(m_temp[k])));
      check("min", 32'(mn[k]), 32'(tw(model_min())));
      check("max", 32'(mx[k]), 32'(tw(model_max())));
      check("mm_valid", 32'(mmv[k]), 32'd1);
      check("window_full", 32'(wf[k]), 32'(hist.size() >= NW[k]));
      check("alarm", 32'(al[k]), 32'(m_alarm));
      check("ready_back", 32'(rdy[k]), 32'd1);
    end
    if (clr_mid) m_clr_pend = 1'b1;
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    @(posedge clk);
    #1;
    clr_i = 1'b0;
    hist.delete();
    m_clr_pend = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("clear_mmv", 32'(mmv[k]), 32'd0);
      check("clear_full", 32'(wf[k]), 32'd0);
      check("clear_alarm_kept", 32'(al[k]), 32'(m_alarm));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sample_i = '0;
    sample_valid_i = 1'b0;
    mode_i = 2'd0;
    hold_i = 1'b0;
    clr_i = 1'b0;
    m_temp = '{0, 0};
    m_alarm = 1'b0;
    m_clr_pend = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) check("ready_after_reset", 32'(rdy[k]), 32'd1);

    // First sample, mode current.
    send(400, 0, 0, 0, 0);

    // Window fill and roll-over: 8x400 then 8x560 averaged.
    do_clear();
    for (int i = 0; i < 16; i++) begin
      send((i < 8) ? 400 : 560, 1, 0, 0, 0);
      if (i == 0)  check("avg8_first", 32'(tmp[0]), 32'd50);
      if (i == 7)  check("avg8_full", 32'(tmp[0]), 32'd400);
      if (i == 11) check("avg8_mid", 32'(tmp[0]), 32'd480);
      if (i == 15) check("avg8_end", 32'(tmp[0]), 32'd560);
    end

    // Negative average rounds toward minus infinity.
    do_clear();
    send(-168, 1, 0, 0, 0);
    send(-167, 1, 0, 0, 0);
    check("avg2_floor", 32'(tmp[1]), 32'h1F58);

    // Alarm hysteresis, then misordered thresholds.
    thr_hi = 480;
    thr_lo = 448;
    send(470, 0, 0, 0, 0);
    send(490, 0, 0, 0, 0);
    send(460, 0, 0, 0, 0);
    send(440, 0, 0, 0, 0);
    thr_lo = 500;
    send(490, 0, 0, 0, 0);
    check("alarm_set_wins", 32'(al[0]), 32'd1);
    thr_hi = 4095;
    thr_lo = -4096;

    // Min/max, with a clear pulsed while the last sample is being accumulated.
    do_clear();
    send(400, 2, 0, 0, 0);
    send(-168, 3, 0, 0, 0);
    send(560, 2, 0, 1, 0);
    send(300, 1, 0, 0, 0);
    check("post_clear_avg", 32'(tmp[0]), 32'd37);

    // Hold freezes temp_o; valid kept high while busy must not cause a second accept.
    send(500, 0, 1, 0, 1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) check("no_extra_accept", 32'(rdy[k]), 32'd1);

    // Reset while in S_PUBLISH.
    sample_i = tw(123);
    sample_valid_i = 1'b1;
    mode_i = 2'd0;
    hold_i = 1'b0;
    @(posedge clk);
    #1;
    sample_valid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("reset_publish");
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    m_temp = '{0, 0};
    m_alarm = 1'b0;
    m_clr_pend = 1'b0;
    #1;

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      int v;
      v = int'($urandom_range(0, 8191)) - 4096;
      if ($urandom_range(0, 9) == 0) begin
        thr_hi = int'($urandom_range(0, 8191)) - 4096;
        thr_lo = int'($urandom_range(0, 8191)) - 4096;
      end
      if ($urandom_range(0, 15) == 0) do_clear();
      send(v, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
